// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
// Contents: op encodings, FSM state enum, datapath mode enum, iteration count.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // One iteration per operand bit; the counter runs ITER-1 down to 0.
    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

endpackage

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one combinational shift-add / restoring-divide iteration
// Ports:
//   mode     - MODE_MUL: shift-add step, MODE_DIV: restoring divide step
//   acc      - 2*WIDTH accumulator {upper, lower}
//   opnd     - multiplicand (mul) or divisor (div) magnitude
//   acc_next - accumulator after this step (quotient bit slot left 0)
//   q_bit    - quotient bit produced by a divide step (0 in mul mode)
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mode_t              mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted_rem;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        acc_next    = '0;
        q_bit       = 1'b0;
        sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        // Partial remainder shifted left by one; it can need WIDTH+1 bits
        // because the previous remainder is only bounded by the divisor.
        shifted_rem = acc[2*WIDTH-1:WIDTH-1];
        ge          = shifted_rem >= {1'b0, opnd};
        rem_sub     = acc[2*WIDTH-2:WIDTH-1] - opnd;

        if (mode == MODE_DIV) begin
            if (ge) begin
                q_bit    = 1'b1;
                acc_next = {rem_sub, acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            // Multiplier sits in the low half and is consumed LSB first.
            if (acc[0]) begin
                acc_next = {sum, acc[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start, op     - launch (sampled in IDLE only), op select 00/01/10/11
//   a, b          - rs / rt operands
//   hi_we, lo_we  - MTHI / MTLO write enables (IDLE only), data on wd
//   busy, done    - operation in flight, one-cycle result pulse
//   hi, lo        - HI / LO registers
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    mode_t              mode;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
        prod_fix  = neg_res ? (~acc + 1'b1) : acc;
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .mode     (mode),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            mode     <= MODE_MUL;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wd;
                    if (lo_we) lo <= wd;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        cnt      <= CW'(ITER - 1);
                        acc      <= {{WIDTH{1'b0}}, a_mag};
                        opnd     <= b_mag;
                        mode     <= op[1] ? MODE_DIV : MODE_MUL;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (b == '0);
                    end
                end
                RUN: begin
                    acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    if (mode == MODE_MUL) begin
                        {hi, lo} <= prod_fix;
                    end else begin
                        // Divide by zero leaves |a| as the remainder; restoring
                        // its sign yields HI = a, and LO is forced to all ones.
                        if (div_zero)     lo <= '1;
                        else if (neg_res) lo <= ~acc[WIDTH-1:0] + 1'b1;
                        else              lo <= acc[WIDTH-1:0];
                        hi <= neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS32 SOC datapath. It sits directly downstream of the register file. It takes the two register-file read operands (rd1 → a, rd2 → b) and executes MULT, MULTU, DIV and DIVU over 33 cycles. It holds HI/LO for MFHI/MFLO reads and MTHI/MTLO writes. While it is busy, the hazard unit stalls any instruction that touches HI/LO.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports (clock and reset first):
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch an operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  operand rs (register file rd1).
- b  in  WIDTH  operand rt (register file rd2).
- hi_we  in  1  MTHI: HI <= wd.
- lo_we  in  1  MTLO: LO <= wd.
- wd  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE → RUN on start.
  - RUN → FIX after exactly 32 iterations (5-bit counter, 31 down to 0).
  - FIX → IDLE unconditionally.
- Launch:
  - a, b and op are latched on the start edge.
  - Signed ops latch magnitudes and record the result signs.
- MULT/MULTU: shift-add on a 64-bit accumulator, one multiplier bit per iteration.
- DIV/DIVU: restoring division, one quotient bit per iteration.
- FIX state:
  - Signed multiply: negate the 64-bit product if sign(a) ≠ sign(b).
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of a.
  - {HI, LO} = product; LO = quotient, HI = remainder.
- Divide by zero (no trap): LO = 32'hFFFFFFFF, HI = a, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO:
  - Applied in IDLE only; ignored in RUN and FIX.
  - hi_we and lo_we may both be asserted in the same cycle.
- Start while busy is ignored. The in-flight operation is unaffected.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0.
- Reset mid-operation aborts the operation with no partial HI/LO update.
- Edge E0 samples start in IDLE. The iterations run on E1..E32. FIX writes HI/LO on E33.
- busy is registered: high from after E0 until E33; low in the cycle after E33.
- done is registered: high for exactly the one cycle after E33, the same cycle HI/LO first show the result.
- Back-to-back operation: a start in the done cycle is accepted. No dead cycle is required.
- start with hi_we/lo_we on the same IDLE edge: both take effect, and the operation result overwrites HI/LO at E33.
- hi/lo are direct register outputs, with no combinational path from inputs.

## Structure
- Package mdu_pkg holds:
  - the op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum: IDLE, RUN, FIX;
  - ITER = 32.
- Sub-module mdu_iter_step: one combinational iteration.
  - Inputs: mode (mul/div), 64-bit accumulator, operand register.
  - Outputs: next accumulator and next quotient bit.
  - Instantiated once in the top-level datapath.
- The top level owns the FSM, counter, sign flags, the FIX negation logic and HI/LO.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at E33+1; HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
- MULT a=-7 (0xFFFFFFF9), b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFEB.
- DIV a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 in IDLE → hi=0x1234 next cycle. MTLO during RUN → ignored. Second start at E10 → ignored; the first result is intact.
- rst asserted at E15 of a DIV → busy=0 and hi=lo=0 immediately (asynchronously). A new MULTU 3×4 then completes → LO=12, HI=0.
